// File: rtl/tlu_pkg.sv
// Shared definitions for the TLU trigger sequence checker: trigger/marker word
// layout, default marker tag and checker state encoding.
package tlu_pkg;

  localparam int TRIGGER_WORD_BIT = 31;

  localparam int MARKER_ID_MSB    = 30;
  localparam int MARKER_ID_LSB    = 24;
  localparam int MARKER_DUP_BIT   = 23;
  localparam int MARKER_COUNT_MSB = 22;
  localparam int MARKER_COUNT_W   = MARKER_COUNT_MSB + 1;

  localparam logic [6:0] MARKER_ID_DEFAULT = 7'h7E;

  typedef enum logic {
    PASS = 1'b0,
    MARK = 1'b1
  } chk_state_e;

  // Marker words are never trigger words, so bit 31 is always left at zero.
  function automatic logic [31:0] build_marker(
    input logic [6:0]                id,
    input logic                      dup,
    input logic [MARKER_COUNT_W-1:0] missed
  );
    logic [31:0] w;
    w                                = '0;
    w[MARKER_ID_MSB:MARKER_ID_LSB]   = id;
    w[MARKER_DUP_BIT]                = dup;
    w[MARKER_COUNT_MSB:0]            = missed;
    return w;
  endfunction

endpackage

// File: rtl/tlu_trigger_seq_checker_fwft_out_reg.sv
// Single-entry first-word-fall-through output register: holds one word and
// accepts a new one whenever it is empty or being popped in the same cycle.
module fwft_out_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_req_i,
  input  logic [WIDTH-1:0] load_data_i,
  input  logic             out_read_i,
  output logic             load_en_o,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] out_data_o
);

  logic             valid_q;
  logic [WIDTH-1:0] data_q;

  // A pop while empty is harmless: load_en is already high from !valid_q.
  assign load_en_o   = !valid_q | out_read_i;
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load_en_o) begin
      valid_q <= load_req_i;
      if (load_req_i) begin
        data_q <= load_data_i;
      end
    end
  end

endmodule

// File: rtl/tlu_trigger_seq_checker.sv
// Trigger-number continuity checker between the TLU readout FIFO and the BRAM
// FIFO; inserts a marker word ahead of every out-of-sequence trigger word.
module tlu_trigger_seq_checker
  import tlu_pkg::*;
#(
  parameter int         TRIGGER_BITS = 15,
  parameter logic [6:0] MARKER_ID    = MARKER_ID_DEFAULT
) (
  input  logic                    BUS_CLK,
  input  logic                    BUS_RST,
  input  logic                    ENABLE,
  input  logic                    CLEAR_COUNT,
  output logic                    IN_READ,
  input  logic                    IN_EMPTY,
  input  logic [31:0]             IN_DATA,
  input  logic                    OUT_READ,
  output logic                    OUT_EMPTY,
  output logic [31:0]             OUT_DATA,
  output logic [15:0]             ERROR_COUNT,
  output logic [31:0]             MISSED_COUNT,
  output logic [TRIGGER_BITS-1:0] LAST_TRIGGER
);

  chk_state_e              state_q, state_d;
  logic                    baseline_valid_q, baseline_valid_d;
  logic [TRIGGER_BITS-1:0] last_trigger_q, last_trigger_d;
  logic [15:0]             error_count_q, error_count_d;
  logic [31:0]             missed_count_q, missed_count_d;

  logic                      load_en;
  logic                      out_valid;
  logic                      load_req;
  logic [31:0]               load_data;
  logic                      insert_marker;
  logic                      marker_load;
  logic                      accept_trig;
  logic                      trig;
  logic [TRIGGER_BITS-1:0]   num;
  logic [TRIGGER_BITS-1:0]   expected;
  logic                      dup;
  logic [TRIGGER_BITS-1:0]   missed;
  logic [MARKER_COUNT_W-1:0] missed_ext;
  logic [31:0]               marker_word;
  logic [32:0]               missed_sum;

  assign trig        = IN_DATA[TRIGGER_WORD_BIT];
  assign num         = IN_DATA[TRIGGER_BITS-1:0];
  assign expected    = last_trigger_q + TRIGGER_BITS'(1);
  assign dup         = (num == last_trigger_q);
  assign missed      = dup ? '0 : (num - expected);
  assign missed_ext  = MARKER_COUNT_W'(missed);
  assign marker_word = build_marker(MARKER_ID, dup, missed_ext);
  assign missed_sum  = {1'b0, missed_count_q} + 33'(missed);

  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      state_q <= PASS;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_d = state_q;
    unique case (state_q)
      PASS:    if (marker_load) state_d = MARK;
      MARK:    if (load_en && !IN_EMPTY) state_d = PASS;
      default: state_d = PASS;
    endcase
  end

  always_comb begin
    insert_marker = 1'b0;
    if ((state_q == PASS) && ENABLE && !IN_EMPTY && trig && baseline_valid_q
        && (num != expected)) begin
      insert_marker = 1'b1;
    end
    marker_load = insert_marker & load_en;
    // Gated by reset so the upstream FIFO is never popped while the register is held clear.
    IN_READ     = load_en & !IN_EMPTY & !insert_marker & !BUS_RST;
    load_req    = insert_marker | !IN_EMPTY;
    load_data   = insert_marker ? marker_word : IN_DATA;
    accept_trig = IN_READ & trig & (((state_q == PASS) & ENABLE) | (state_q == MARK));
  end

  always_comb begin
    baseline_valid_d = ENABLE & (baseline_valid_q | accept_trig);
    last_trigger_d   = accept_trig ? num : last_trigger_q;
    error_count_d    = error_count_q;
    missed_count_d   = missed_count_q;
    if (CLEAR_COUNT) begin
      error_count_d  = '0;
      missed_count_d = '0;
    end else if (marker_load) begin
      if (error_count_q != 16'hFFFF) begin
        error_count_d = error_count_q + 16'd1;
      end
      missed_count_d = missed_sum[32] ? 32'hFFFF_FFFF : missed_sum[31:0];
    end
  end

  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      baseline_valid_q <= 1'b0;
      last_trigger_q   <= '0;
      error_count_q    <= '0;
      missed_count_q   <= '0;
    end else begin
      baseline_valid_q <= baseline_valid_d;
      last_trigger_q   <= last_trigger_d;
      error_count_q    <= error_count_d;
      missed_count_q   <= missed_count_d;
    end
  end

  fwft_out_reg #(
    .WIDTH(32)
  ) u_out_reg (
    .clk_i      (BUS_CLK),
    .rst_i      (BUS_RST),
    .load_req_i (load_req),
    .load_data_i(load_data),
    .out_read_i (OUT_READ),
    .load_en_o  (load_en),
    .out_valid_o(out_valid),
    .out_data_o (OUT_DATA)
  );

  assign OUT_EMPTY    = !out_valid;
  assign ERROR_COUNT  = error_count_q;
  assign MISSED_COUNT = missed_count_q;
  assign LAST_TRIGGER = last_trigger_q;

endmodule

// File: tb/tb_tlu_trigger_seq_checker.sv
// Self-checking bench: FWFT upstream FIFO model feeding the checker, with a
// scoreboard of expected output words compared as the downstream pops them.
module tb_tlu_trigger_seq_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        clear_count;
  logic        in_read;
  logic        in_empty;
  logic [31:0] in_data;
  logic        out_read;
  logic        out_empty;
  logic [31:0] out_data;
  logic [15:0] error_count;
  logic [31:0] missed_count;
  logic [14:0] last_trigger;

  int checks = 0;
  int errors = 0;

  logic [31:0] in_q[$];
  logic [31:0] exp_q[$];
  bit          pop_pend = 1'b0;

  always #5 clk = ~clk;

  tlu_trigger_seq_checker #(
    .TRIGGER_BITS(15),
    .MARKER_ID   (7'h7E)
  ) dut (
    .BUS_CLK     (clk),
    .BUS_RST     (rst),
    .ENABLE      (enable),
    .CLEAR_COUNT (clear_count),
    .IN_READ     (in_read),
    .IN_EMPTY    (in_empty),
    .IN_DATA     (in_data),
    .OUT_READ    (out_read),
    .OUT_EMPTY   (out_empty),
    .OUT_DATA    (out_data),
    .ERROR_COUNT (error_count),
    .MISSED_COUNT(missed_count),
    .LAST_TRIGGER(last_trigger)
  );

  // Upstream FIFO: pop is sampled on the edge, head is refreshed half a cycle later.
  always @(posedge clk) pop_pend = in_read && !in_empty;

  always @(negedge clk) begin
    if (pop_pend && in_q.size() > 0) void'(in_q.pop_front());
    in_empty = (in_q.size() == 0);
    in_data  = in_empty ? 32'h0 : in_q[0];
  end

  // Downstream scoreboard: a word is consumed on the edge after it is seen here.
  always @(negedge clk) begin
    logic [31:0] exp_w;
    if (out_read && !out_empty) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out_word: got %08h, expected no word", out_data);
      end else begin
        exp_w = exp_q.pop_front();
        if (out_data !== exp_w) begin
          errors++;
          $display("FAIL out_word: got %08h, expected %08h", out_data, exp_w);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] w);
    in_q.push_back(w);
  endtask

  task automatic expect_word(input logic [31:0] w);
    exp_q.push_back(w);
  endtask

  task automatic apply_reset();
    rst         = 1'b1;
    out_read    = 1'b0;
    enable      = 1'b1;
    clear_count = 1'b0;
    in_q.delete();
    exp_q.delete();
    repeat (3) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic drain(input string name);
    int n;
    n        = 0;
    out_read = 1'b1;
    while ((in_q.size() != 0 || exp_q.size() != 0) && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (in_q.size() != 0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s drain: %0d input and %0d expected words left, required 0 and 0",
               name, in_q.size(), exp_q.size());
    end
    repeat (2) tick();
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    enable      = 1'b1;
    clear_count = 1'b0;
    out_read    = 1'b0;
    in_empty    = 1'b1;
    in_data     = 32'h0;
    send(32'h00C0FFEE);
    expect_word(32'h00C0FFEE);
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (out_empty !== 1'b1) begin errors++; $display("FAIL reset out_empty: got %0b, expected 1", out_empty); end
    checks++;
    if (out_data !== 32'h0) begin errors++; $display("FAIL reset out_data: got %08h, expected 00000000", out_data); end
    checks++;
    if (in_read !== 1'b0) begin errors++; $display("FAIL reset in_read: got %0b, expected 0", in_read); end
    checks++;
    if (error_count !== 16'h0) begin errors++; $display("FAIL reset error_count: got %0d, expected 0", error_count); end
    checks++;
    if (missed_count !== 32'h0) begin errors++; $display("FAIL reset missed_count: got %0d, expected 0", missed_count); end
    checks++;
    if (last_trigger !== 15'h0) begin errors++; $display("FAIL reset last_trigger: got %0h, expected 0", last_trigger); end
    tick();
    rst = 1'b0;
    drain("reset");
  endtask

  task automatic test_continuity();
    apply_reset();
    send(32'h80000005); expect_word(32'h80000005);
    send(32'h80000006); expect_word(32'h80000006);
    send(32'h80000007); expect_word(32'h80000007);
    send(32'h12345678); expect_word(32'h12345678);
    drain("continuity");
    checks++;
    if (error_count !== 16'd0) begin errors++; $display("FAIL continuity error_count: got %0d, expected 0", error_count); end
    checks++;
    if (last_trigger !== 15'h7) begin errors++; $display("FAIL continuity last_trigger: got %0h, expected 7", last_trigger); end
  endtask

  task automatic test_gap();
    apply_reset();
    send(32'h80000005); expect_word(32'h80000005);
    send(32'h80000009); expect_word(32'h7E000003); expect_word(32'h80000009);
    drain("gap");
    checks++;
    if (error_count !== 16'd1) begin errors++; $display("FAIL gap error_count: got %0d, expected 1", error_count); end
    checks++;
    if (missed_count !== 32'd3) begin errors++; $display("FAIL gap missed_count: got %0d, expected 3", missed_count); end
    checks++;
    if (last_trigger !== 15'h9) begin errors++; $display("FAIL gap last_trigger: got %0h, expected 9", last_trigger); end
  endtask

  task automatic test_wrap_dup();
    apply_reset();
    send(32'h80007FFF); expect_word(32'h80007FFF);
    send(32'h80000000); expect_word(32'h80000000);
    drain("wrap");
    checks++;
    if (error_count !== 16'd0) begin errors++; $display("FAIL wrap error_count: got %0d, expected 0", error_count); end
    send(32'h80000000); expect_word(32'h7E800000); expect_word(32'h80000000);
    drain("dup");
    checks++;
    if (error_count !== 16'd1) begin errors++; $display("FAIL dup error_count: got %0d, expected 1", error_count); end
    checks++;
    if (missed_count !== 32'd0) begin errors++; $display("FAIL dup missed_count: got %0d, expected 0", missed_count); end
  endtask

  task automatic test_back_pressure();
    apply_reset();
    out_read = 1'b0;
    send(32'h80000005); expect_word(32'h80000005);
    send(32'h80000009); expect_word(32'h7E000003); expect_word(32'h80000009);
    repeat (2) tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (in_read !== 1'b0 || out_empty !== 1'b0 || out_data !== 32'h80000005) begin
        errors++;
        $display("FAIL back_pressure hold %0d: in_read=%0b out_empty=%0b out_data=%08h, expected 0 0 80000005",
                 i, in_read, out_empty, out_data);
      end
    end
    checks++;
    if (in_q.size() != 1 || error_count !== 16'd0) begin
      errors++;
      $display("FAIL back_pressure pending: upstream words %0d error_count %0d, expected 1 and 0",
               in_q.size(), error_count);
    end
    drain("back_pressure");
    checks++;
    if (error_count !== 16'd1 || missed_count !== 32'd3) begin
      errors++;
      $display("FAIL back_pressure counts: got %0d/%0d, expected 1/3", error_count, missed_count);
    end
  endtask

  task automatic test_enable_clear();
    apply_reset();
    send(32'h80000005); expect_word(32'h80000005);
    drain("enable_base");
    enable = 1'b0;
    send(32'h80000009); expect_word(32'h80000009);
    drain("enable_off");
    checks++;
    if (error_count !== 16'd0) begin errors++; $display("FAIL enable_off error_count: got %0d, expected 0", error_count); end
    enable = 1'b1;
    send(32'h80000014); expect_word(32'h80000014);
    drain("rebaseline");
    checks++;
    if (error_count !== 16'd0 || last_trigger !== 15'h14) begin
      errors++;
      $display("FAIL rebaseline: error_count %0d last_trigger %0h, expected 0 and 14", error_count, last_trigger);
    end
    send(32'h80000016); expect_word(32'h7E000001); expect_word(32'h80000016);
    drain("gap_before_clear");
    checks++;
    if (error_count !== 16'd1 || missed_count !== 32'd1) begin
      errors++;
      $display("FAIL gap_before_clear counts: got %0d/%0d, expected 1/1", error_count, missed_count);
    end
    out_read = 1'b0;
    send(32'h0000AAAA); expect_word(32'h0000AAAA);
    repeat (3) tick();
    send(32'h80000019); expect_word(32'h7E000002); expect_word(32'h80000019);
    repeat (3) tick();
    out_read    = 1'b1;
    clear_count = 1'b1;
    tick();
    clear_count = 1'b0;
    drain("clear");
    checks++;
    if (error_count !== 16'd0 || missed_count !== 32'd0) begin
      errors++;
      $display("FAIL clear counts: got %0d/%0d, expected 0/0", error_count, missed_count);
    end
    checks++;
    if (last_trigger !== 15'h19) begin errors++; $display("FAIL clear last_trigger: got %0h, expected 19", last_trigger); end
  endtask

  task automatic test_reset_mid_mark();
    apply_reset();
    out_read = 1'b0;
    send(32'h80000005); expect_word(32'h80000005);
    send(32'h80000009); expect_word(32'h7E000003);
    repeat (3) tick();
    out_read = 1'b1;
    tick();
    out_read = 1'b0;
    repeat (2) tick();
    checks++;
    if (out_empty !== 1'b0 || out_data !== 32'h7E000003 || error_count !== 16'd1) begin
      errors++;
      $display("FAIL mid_mark setup: out_empty=%0b out_data=%08h error_count=%0d, expected 0 7e000003 1",
               out_empty, out_data, error_count);
    end
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out_empty !== 1'b1 || error_count !== 16'd0 || missed_count !== 32'd0) begin
      errors++;
      $display("FAIL async_reset: out_empty=%0b error_count=%0d missed_count=%0d, expected 1 0 0",
               out_empty, error_count, missed_count);
    end
    exp_q.delete();
    expect_word(32'h80000009);
    repeat (2) tick();
    rst = 1'b0;
    drain("after_reset");
    checks++;
    if (error_count !== 16'd0 || last_trigger !== 15'h9) begin
      errors++;
      $display("FAIL after_reset: error_count %0d last_trigger %0h, expected 0 and 9", error_count, last_trigger);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_continuity();
    test_gap();
    test_wrap_dup();
    test_back_pressure();
    test_enable_clear();
    test_reset_mid_mark();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tlu_trigger_seq_checker.md
Name: tlu_trigger_seq_checker

Overview:
- Stream stage between the TLU controller's readout FIFO port and the BRAM FIFO. It consumes 32-bit words using the FIFO_READ/FIFO_EMPTY/FIFO_DATA first-word-fall-through handshake.
- Non-trigger data words pass through unchanged.
- Trigger words (bit31 = 1) are checked for trigger-number continuity. On each gap or duplicate, a marker word is inserted ahead of the offending trigger word.
- Error and missed-trigger counters are exported for status readout.

Parameters:
- TRIGGER_BITS, 15, width of the trigger number in data[TRIGGER_BITS-1:0]; legal range 1..23.
- MARKER_ID, 7'h7E, tag placed in marker bits[30:24].

Ports:
- BUS_CLK  in  1  single clock.
- BUS_RST  in  1  asynchronous active-high reset.
- ENABLE  in  1  1 = check and insert markers; 0 = pure pass-through.
- CLEAR_COUNT  in  1  synchronous clear of both counters.
- IN_READ  out  1  pop strobe to upstream FIFO.
- IN_EMPTY  in  1  upstream has no valid word.
- IN_DATA  in  32  upstream head word, valid while !IN_EMPTY.
- OUT_READ  in  1  pop strobe from downstream.
- OUT_EMPTY  out  1  no valid output word.
- OUT_DATA  out  32  output head word, valid while !OUT_EMPTY.
- ERROR_COUNT  out  16  number of markers inserted; saturates at 16'hFFFF.
- MISSED_COUNT  out  32  sum of missed-trigger counts; saturates at 32'hFFFFFFFF.
- LAST_TRIGGER  out  TRIGGER_BITS  last accepted trigger number.

Behaviour:
- Reset values (asynchronous):
  - Outputs: OUT_EMPTY = 1, OUT_DATA = 0, IN_READ = 0, ERROR_COUNT = 0, MISSED_COUNT = 0, LAST_TRIGGER = 0.
  - Internal: baseline_valid = 0, marker_pending = 0.
- Output register:
  - One register (out_valid, out_data); OUT_EMPTY = !out_valid.
  - load_en = !out_valid | OUT_READ.
  - OUT_READ while OUT_EMPTY is ignored.
- Latency and throughput: a word popped in cycle N appears at OUT_DATA in cycle N+1. Throughput is 1 word/cycle; a marker costs one extra cycle.
- IN_READ = load_en & !IN_EMPTY & !insert_marker (combinational). Data is never dropped or duplicated.
- Classification:
  - trig = IN_DATA[31].
  - num = IN_DATA[TRIGGER_BITS-1:0].
  - expected = LAST_TRIGGER + 1, computed modulo 2^TRIGGER_BITS (wraps max to 0).
- State machine (states PASS, MARK):
  - PASS:
    - Head is a non-trigger word, or ENABLE = 0: forward the word.
    - Trigger head with baseline_valid = 0: forward it, set LAST_TRIGGER = num, set baseline_valid.
    - Trigger head with num == expected: forward it, set LAST_TRIGGER = num.
    - Trigger head with num != expected, when load_en = 1:
      - Load the marker without popping upstream.
      - Increment ERROR_COUNT; add missed to MISSED_COUNT.
      - Go to MARK.
  - MARK: when load_en = 1 and !IN_EMPTY, forward the held trigger word (pop), set LAST_TRIGGER = num, return to PASS.
- Marker word layout:
  - bit31 = 0.
  - bits[30:24] = MARKER_ID.
  - bit23 = dup.
  - bits[22:0] = missed, zero-extended.
  - missed = (num - expected) mod 2^TRIGGER_BITS.
  - dup = (num == LAST_TRIGGER); when dup = 1, missed is forced to 0 and MISSED_COUNT is not incremented.
- ENABLE:
  - ENABLE = 0 clears baseline_valid, so the first trigger after re-enable re-baselines.
  - ENABLE dropping while in MARK: the held trigger is still forwarded. No word is lost.
- CLEAR_COUNT:
  - Clears ERROR_COUNT and MISSED_COUNT on the next edge.
  - If CLEAR_COUNT coincides with an increment, clear wins.
  - Does not affect the baseline or the data path.
- Counters saturate; they do not wrap.
- Reset mid-stream: any pending marker or held state is discarded. The upstream word that was not popped remains in the upstream FIFO.

Decomposition:
- Shared package tlu_pkg holds:
  - the TRIGGER_WORD_BIT (31) constant;
  - the marker field offsets (ID 30:24, DUP 23, COUNT 22:0);
  - the default MARKER_ID;
  - the state enum {PASS, MARK}.
- One natural sub-module: fwft_out_reg, the single-entry output register with load_en/valid logic.
- The checker FSM and counters stay in the top module.

Test Plan:
- Continuity: with ENABLE = 1, feed triggers 0x80000005, 0x80000006, 0x80000007 and data word 0x12345678 → output is identical and in order; ERROR_COUNT = 0; LAST_TRIGGER = 7.
- Gap: feed triggers 5 then 9 →
  - output is 0x80000005, then marker 0x7E000003, then 0x80000009;
  - ERROR_COUNT = 1; MISSED_COUNT = 3.
- Wrap and duplicate: with TRIGGER_BITS = 15, feed trigger 0x7FFF then 0x0000 → no marker. Then feed 0x0000 again → marker 0x7E800000, followed by the trigger; MISSED_COUNT unchanged.
- Back-pressure: hold OUT_READ = 0 for 10 cycles while the gap case is pending → IN_READ stays low and nothing is lost; after release the order is exactly marker then trigger.
- ENABLE/CLEAR:
  - With ENABLE = 0 and a gap 5→9, there is no marker.
  - Re-enable and feed 20 → re-baseline, no marker.
  - Assert CLEAR_COUNT in the same cycle as a marker load → ERROR_COUNT = 0.
- Reset mid-MARK: assert BUS_RST asynchronously between marker and trigger → OUT_EMPTY goes to 1 immediately and counters go to 0. The trigger word is still at upstream head and is forwarded as a new baseline after reset.
